// File: rtl/mux2x1_rr_arb_if.sv
// Handshake bundle for the 2:1 round-robin stream arbiter: two sources in, one registered stream out.
interface mux2x1_rr_arb_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] y;
    logic             y_src;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output a, a_valid, b, b_valid, y_ready,
        input  a_ready, b_ready, y, y_src, y_valid
    );

    modport slave (
        input  a, a_valid, b, b_valid, y_ready,
        output a_ready, b_ready, y, y_src, y_valid
    );
endinterface

// File: rtl/mux2x1_rr_arb.sv
// Round-robin arbiter driving the sel of a 2:1 mux, with a registered output word
// and saturating per-source grant counters for debug.
module mux2x1_rr_arb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux2x1_rr_arb_if.slave   bus,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic [WIDTH-1:0] y_p0;
    logic             y_src_p0;
    logic             vld_p0;
    logic             last_p0;
    logic             sel_p0;
    logic [CNT_W-1:0] cnt_a_p0;
    logic [CNT_W-1:0] cnt_b_p0;

    logic load;
    logic any_req;
    logic grant_b;
    logic xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        any_req = bus.a_valid | bus.b_valid;
        grant_b = sel_p0;
        if (bus.a_valid && !bus.b_valid)
            grant_b = 1'b0;
        else if (!bus.a_valid && bus.b_valid)
            grant_b = 1'b1;
        else if (bus.a_valid && bus.b_valid)
            grant_b = ~last_p0;
    end

    // Ready depends combinationally on y_ready so the stage sustains one word per cycle.
    assign load        = ~vld_p0 | bus.y_ready;
    assign bus.a_ready = load & any_req & ~grant_b;
    assign bus.b_ready = load & any_req &  grant_b;
    assign xfer        = bus.a_ready | bus.b_ready;
    assign sel         = any_req ? grant_b : sel_p0;

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p0     <= '0;
            y_src_p0 <= 1'b0;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b1;
            sel_p0   <= 1'b0;
            cnt_a_p0 <= '0;
            cnt_b_p0 <= '0;
        end else begin
            if (any_req)
                sel_p0 <= grant_b;
            if (xfer) begin
                y_p0     <= grant_b ? bus.b : bus.a;
                y_src_p0 <= grant_b;
                vld_p0   <= 1'b1;
                last_p0  <= grant_b;
                if (grant_b)
                    cnt_b_p0 <= sat_inc(cnt_b_p0);
                else
                    cnt_a_p0 <= sat_inc(cnt_a_p0);
            end else if (bus.y_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.y       = y_p0;
    assign bus.y_src   = y_src_p0;
    assign bus.y_valid = vld_p0;
    assign cnt_a       = cnt_a_p0;
    assign cnt_b       = cnt_b_p0;

endmodule

// File: tb/tb_mux2x1_rr_arb.sv
// Bench for mux2x1_rr_arb: a rule-level model checked every cycle plus directed literal checks,
// run on a CNT_W=8 and a CNT_W=2 instance sharing the same stimulus.
module tb_mux2x1_rr_arb;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic a_valid = 1'b0;
    logic b_valid = 1'b0;
    logic y_ready = 1'b1;

    mux2x1_rr_arb_if #(.WIDTH(WIDTH)) bus8 ();
    mux2x1_rr_arb_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus8.a = a;  assign bus8.a_valid = a_valid;
    assign bus8.b = b;  assign bus8.b_valid = b_valid;
    assign bus8.y_ready = y_ready;
    assign bus2.a = a;  assign bus2.a_valid = a_valid;
    assign bus2.b = b;  assign bus2.b_valid = b_valid;
    assign bus2.y_ready = y_ready;

    logic       sel8, sel2;
    logic [7:0] cnt_a8, cnt_b8;
    logic [1:0] cnt_a2, cnt_b2;

    mux2x1_rr_arb #(.WIDTH(WIDTH), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave), .sel(sel8), .cnt_a(cnt_a8), .cnt_b(cnt_b8)
    );
    mux2x1_rr_arb #(.WIDTH(WIDTH), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .sel(sel2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rules: -1 none, 0 A, 1 B.
    function automatic int pick(input logic av, input logic bv, input int last);
        if (av && !bv) return 0;
        if (bv && !av) return 1;
        if (av && bv)  return 1 - last;
        return -1;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Model state: unbounded counts, saturated only when compared.
    int         m_ca, m_cb, m_last, m_sel;
    logic       m_vld, m_src;
    logic [7:0] m_y;

    always @(posedge clk or negedge rst_n) begin : model
        int  p;
        logic ld;
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_y    <= '0;
            m_src  <= 1'b0;
            m_sel  <= 0;
            m_last <= 1;
            m_ca   <= 0;
            m_cb   <= 0;
        end else begin
            p  = pick(a_valid, b_valid, m_last);
            ld = !m_vld || y_ready;
            if (p >= 0) m_sel <= p;
            if (p >= 0 && ld) begin
                m_vld  <= 1'b1;
                m_y    <= (p == 1) ? b : a;
                m_src  <= p[0];
                m_last <= p;
                if (p == 0) m_ca <= m_ca + 1;
                else        m_cb <= m_cb + 1;
            end else if (y_ready) begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int   p;
        logic ld;
        p  = pick(a_valid, b_valid, m_last);
        ld = !m_vld || y_ready;
        chk("a_ready", bus8.a_ready, ld && p == 0);
        chk("b_ready", bus8.b_ready, ld && p == 1);
        chk("sel", sel8, (p >= 0) ? p : m_sel);
        chk("y_valid", bus8.y_valid, m_vld);
        chk("y", bus8.y, m_y);
        chk("y_src", bus8.y_src, m_src);
        chk("cnt_a8", cnt_a8, sat(m_ca, 255));
        chk("cnt_b8", cnt_b8, sat(m_cb, 255));
        chk("y_valid2", bus2.y_valid, m_vld);
        chk("y2", bus2.y, m_y);
        chk("cnt_a2", cnt_a2, sat(m_ca, 3));
        chk("cnt_b2", cnt_b2, sat(m_cb, 3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq [6];
    logic [1:0] sat_seq [5];

    initial begin
        seq = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB};
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst y_valid", bus8.y_valid, 0);
        chk("rst y", bus8.y, 0);
        chk("rst sel", sel8, 0);
        chk("rst cnt_a", cnt_a8, 0);
        rst_n = 1'b1;

        // Single A word
        tick();
        a_valid = 1'b1; a = 8'h11; y_ready = 1'b1;
        #1;
        chk("first a_ready", bus8.a_ready, 1);
        chk("first sel", sel8, 0);
        tick();
        chk("first y", bus8.y, 8'h11);
        chk("first y_src", bus8.y_src, 0);
        chk("first y_valid", bus8.y_valid, 1);
        chk("first cnt_a", cnt_a8, 1);
        a_valid = 1'b0;

        // Drain with no new word
        tick();
        chk("drain y_valid", bus8.y_valid, 0);
        chk("drain cnt_a", cnt_a8, 1);
        chk("drain cnt_b", cnt_b8, 0);

        // Backpressure while B waits
        a_valid = 1'b1; a = 8'h11;
        tick();
        a_valid = 1'b0; b_valid = 1'b1; b = 8'h22; y_ready = 1'b0;
        #1;
        chk("bp b_ready", bus8.b_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp y hold", bus8.y, 8'h11);
            chk("bp b_ready hold", bus8.b_ready, 0);
        end
        y_ready = 1'b1;
        #1;
        chk("bp release b_ready", bus8.b_ready, 1);
        tick();
        chk("bp y", bus8.y, 8'h22);
        chk("bp y_src", bus8.y_src, 1);
        b_valid = 1'b0;

        // Reset pulse mid-stream (y_valid is 1 here)
        rst_n = 1'b0;
        #1;
        chk("midrst y_valid", bus8.y_valid, 0);
        chk("midrst cnt_a", cnt_a8, 0);
        chk("midrst cnt_b", cnt_b8, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Fairness: both valid, tie goes to A first after reset
        a_valid = 1'b1; a = 8'hAA; b_valid = 1'b1; b = 8'hBB;
        #1;
        chk("tie a_ready", bus8.a_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr y", bus8.y, seq[i]);
        end
        chk("rr cnt_a", cnt_a8, 3);
        chk("rr cnt_b", cnt_b8, 3);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Counter saturation on the CNT_W=2 instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(i + 1);
            tick();
            chk("sat y", bus2.y, 8'(i + 1));
            chk("sat cnt_a2", cnt_a2, sat_seq[i]);
        end
        a_valid = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
